io_responder: RTL and testbench
===============================

Name: io_responder

Overview:
- Peripheral on the far end of the core's byte-wide IO bus (ioout/iowrite/ioread/ioin/int).
- Buffers bytes the core writes into a TX FIFO and drains them to an external device over a valid/ready stream.
- Buffers bytes arriving from the device into an RX FIFO that the core reads.
- Raises the core's interrupt while RX data is pending.

Parameters:
- DEPTH, 4: entries per FIFO; power of two, minimum 2.
- AW, log2(DEPTH): pointer width; count width is AW+1.

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- ioout  input  8  byte from core, valid when iowrite=1
- iowrite  input  1  core write strobe, one byte per cycle high
- ioread  input  1  core read strobe; pops RX head at the clock edge
- ioin  output  8  RX head byte presented to core
- int  output  1  interrupt request to core
- tx_data  output  8  byte to device
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  device accepts tx_data
- rx_data  input  8  byte from device
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  responder can accept rx_data
- tx_overflow  output  1  sticky: core wrote while TX full
- rx_underflow  output  1  sticky: core read while RX empty

Behaviour:
- Reset values (edge with reset=1, overriding all other inputs that cycle):
  - FIFO pointers and counts = 0.
  - ioin=8'h00, int=0, tx_valid=0, rx_ready=1, tx_overflow=0, rx_underflow=0.
  - Storage contents are don't-care.
- Reset mid-transfer: all queued bytes are discarded; nothing is flushed.
- TX path:
  - Edge with iowrite=1 and tx_count<DEPTH: push ioout.
  - If tx_count==DEPTH: byte dropped, tx_overflow set.
  - Full-check uses the pre-edge count. A write while full is dropped even if a device pop occurs the same edge.
  - tx_valid = (tx_count!=0); tx_data = TX head (combinational from storage). tx_data is held stable while tx_valid=1 and tx_ready=0.
  - Pop on edge with tx_valid & tx_ready.
  - Push and pop on the same edge (not full) leave the count unchanged.
  - Latency: a byte written at edge N is visible on tx_data/tx_valid after edge N (cycle N+1) when TX was empty. No bypass.
- RX path:
  - rx_ready = (rx_count<DEPTH). Push rx_data on edge with rx_valid & rx_ready.
  - ioin = RX head when rx_count!=0, else 8'h00 (combinational). The core samples it in the same cycle as ioread.
  - Pop on edge with ioread=1 and rx_count!=0.
  - ioread with rx_count==0: no state change except rx_underflow set; ioin reads 8'h00.
  - Simultaneous push and pop: allowed whenever rx_ready=1 and rx_count!=0; count unchanged.
  - When full, rx_ready=0 for that cycle even if ioread pops; there is no same-cycle bypass.
- Interrupt: int = (rx_count!=0), level-sensitive. It deasserts in the cycle after the edge that pops the last byte, unless a push occurs at the same edge.
- iowrite and ioread in the same cycle: independent; both take effect.
- Pointers wrap modulo DEPTH. Counts range 0..DEPTH and never wrap.
- Sticky flags clear only on reset.
- No combinational path from any input to rx_ready or tx_valid; both depend on counts only.

Decomposition:
- Shared include: IO_WIDTH=8 and IO_IDLE_READ=8'h00.
- One sub-module, sync_fifo(WIDTH, DEPTH), instantiated twice (TX and RX).
  - Ports: clock, reset, push, push_data, pop, head, count, full, empty.
  - Push is ignored when full; pop is ignored when empty.
- Top level: strobe qualification, sticky flags, interrupt.

Test Plan:
- Reset then idle: tx_valid=0, rx_ready=1, int=0, ioin=8'h00, both flags 0.
- TX order: with tx_ready=0, iowrite 8'h11,22,33,44 on four edges, then a fifth iowrite 8'h55 → 8'h55 dropped, tx_overflow=1. Raise tx_ready → tx_data sequence 11,22,33,44, then tx_valid=0.
- RX/int: push rx_data 8'hA5 → int=1 and ioin=8'hA5 next cycle. ioread → int=0 and ioin=8'h00 next cycle. A further ioread → rx_underflow=1, no other change.
- RX full: push 4 bytes (01..04) → rx_ready=0. A fifth rx_valid is held and not accepted. ioread pops 01 and rx_ready=1 next cycle; the held byte is then accepted. Read order is 02,03,04, then the held byte.
- Concurrency: TX holds 2 bytes with tx_ready=1 and iowrite=1 every cycle for 10 cycles → tx_count stays 2, no overflow, output order equals write order. Same cycle ioread+iowrite → both occur.
- Mid-operation reset: with 3 TX and 2 RX bytes queued, assert reset for one edge → all outputs return to reset values and the queued bytes never appear.

Source files
------------

// File: rtl/io_responder_pkg.sv
// io_responder_pkg
//   Shared definitions for the IO responder: width of the core's byte-wide
//   IO bus and the value presented on ioin when no RX byte is pending.
package io_responder_pkg;

  localparam int         IO_WIDTH     = 8;
  localparam logic [7:0] IO_IDLE_READ = 8'h00;

  typedef logic [IO_WIDTH-1:0] io_byte_t;

endpackage : io_responder_pkg

// File: rtl/io_responder_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a combinational head read.
//   Ports:
//     clock, reset      : rising-edge clock, synchronous active-high reset
//     push, push_data   : write request and data (ignored when full)
//     pop               : read request (ignored when empty)
//     head              : oldest stored entry (don't-care when empty)
//     count             : number of stored entries, 0..DEPTH
//     full, empty       : count == DEPTH / count == 0
module sync_fifo
  import io_responder_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_COUNT = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_COUNT  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] ONE_PTR    = AW'(1'b1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == ZERO_COUNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE_COUNT;
      2'b01:   count_d = count_q - ONE_COUNT;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= ZERO_COUNT;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are not cleared since pointers alone define validity.
  always_ff @(posedge clock) begin
    if (do_push && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule : sync_fifo

// File: rtl/io_responder.sv
// io_responder
//   Peripheral behind the core's byte-wide IO bus. Bytes written by the core
//   are queued in a TX FIFO and streamed to the device; bytes from the device
//   are queued in an RX FIFO that the core reads. The interrupt is asserted
//   while any RX byte is pending.
//   Ports:
//     clock, reset              : rising-edge clock, synchronous active-high reset
//     ioout, iowrite            : core write data / strobe
//     ioread, ioin              : core read strobe / RX head (IO_IDLE_READ when empty)
//     io_int                    : interrupt request (RX not empty)
//     tx_data, tx_valid, tx_ready : stream to the device
//     rx_data, rx_valid, rx_ready : stream from the device
//     tx_overflow, rx_underflow : sticky error flags, cleared only by reset
module io_responder
  import io_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IO_WIDTH-1:0] ioout,
  input  logic                iowrite,
  input  logic                ioread,
  output logic [IO_WIDTH-1:0] ioin,
  output logic                io_int,
  output logic [IO_WIDTH-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [IO_WIDTH-1:0] rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                tx_overflow,
  output logic                rx_underflow
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] ZERO_COUNT = {(AW+1){1'b0}};

  io_byte_t    tx_head;
  io_byte_t    rx_head;
  logic [AW:0] tx_count_unused;
  logic [AW:0] rx_count;
  logic        tx_full, tx_empty;
  logic        rx_full, rx_empty;
  logic        tx_pop;
  logic        rx_push;
  logic        tx_overflow_q, tx_overflow_d;
  logic        rx_underflow_q, rx_underflow_d;

  // Pops/pushes on the device side are qualified by counts only, so the
  // handshake outputs never see a combinational input path.
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_push = rx_valid & rx_ready;

  sync_fifo #(.WIDTH(IO_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (iowrite),
    .push_data (ioout),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count_unused),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(IO_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (ioread),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_head;
  assign rx_ready = ~rx_full;
  assign io_int   = (rx_count != ZERO_COUNT);
  assign ioin     = rx_empty ? IO_IDLE_READ : rx_head;

  // Sticky error flags; the full/empty tests use the pre-edge occupancy.
  always_comb begin
    tx_overflow_d  = tx_overflow_q;
    rx_underflow_d = rx_underflow_q;
    if (iowrite && tx_full) begin
      tx_overflow_d = 1'b1;
    end else begin
      tx_overflow_d = tx_overflow_q;
    end
    if (ioread && rx_empty) begin
      rx_underflow_d = 1'b1;
    end else begin
      rx_underflow_d = rx_underflow_q;
    end
  end

  // Flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      tx_overflow_q  <= tx_overflow_d;
      rx_underflow_q <= rx_underflow_d;
    end
  end

  assign tx_overflow  = tx_overflow_q;
  assign rx_underflow = rx_underflow_q;

endmodule : io_responder

// File: tb/tb_io_responder.sv
// tb_io_responder
//   Self-checking bench for io_responder: directed scenarios plus random
//   traffic, compared against a queue-based reference model.
module tb_io_responder;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ioout = 8'h00;
  logic       iowrite = 1'b0;
  logic       ioread = 1'b0;
  logic [7:0] ioin;
  logic       io_int;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       tx_overflow;
  logic       rx_underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  io_responder #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .ioout        (ioout),
    .iowrite      (iowrite),
    .ioread       (ioread),
    .ioin         (ioin),
    .io_int       (io_int),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_overflow  (tx_overflow),
    .rx_underflow (rx_underflow)
  );

  always #5 clock = ~clock;

  // Observed outputs: [20]tx_valid [19:12]tx_data [11]rx_ready [10:3]ioin [2]int [1]ovf [0]unf
  logic [20:0] obs_vec;
  assign obs_vec = {tx_valid, tx_data, rx_ready, ioin, io_int, tx_overflow, rx_underflow};

  function automatic logic [20:0] exp_vec();
    logic [7:0] txd;
    logic [7:0] rxh;
    txd = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    rxh = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    return {(tx_q.size() != 0), txd, (rx_q.size() < DEPTH), rxh,
            (rx_q.size() != 0), m_ovf, m_unf};
  endfunction

  // tx_data is don't-care while TX is empty
  function automatic logic [20:0] exp_mask();
    return (tx_q.size() != 0) ? 21'h1FFFFF : 21'h100FFF;
  endfunction

  // Advance one clock edge, applying the model's rules to the pre-edge inputs
  task automatic step();
    int pre_tx;
    int pre_rx;
    @(posedge clock);
    pre_tx = tx_q.size();
    pre_rx = rx_q.size();
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (tx_ready && pre_tx != 0) void'(tx_q.pop_front());
      if (iowrite) begin
        if (pre_tx < DEPTH) tx_q.push_back(ioout);
        else m_ovf = 1'b1;
      end
      if (ioread) begin
        if (pre_rx != 0) void'(rx_q.pop_front());
        else m_unf = 1'b1;
      end
      if (rx_valid && pre_rx < DEPTH) rx_q.push_back(rx_data);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if ((obs_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
      errors++;
      $display("FAIL reset_model: got %h expected %h", obs_vec & exp_mask(), exp_vec() & exp_mask());
    end
    checks++;
    if ((obs_vec & 21'h100FFF) !== 21'h000800) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs_vec & 21'h100FFF, 21'h000800);
    end
  endtask

  task automatic test_tx_order();
    logic [7:0] wr [5];
    wr[0] = 8'h11; wr[1] = 8'h22; wr[2] = 8'h33; wr[3] = 8'h44; wr[4] = 8'h55;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iowrite = 1'b1;
      ioout   = wr[i];
      step();
      checks++;
      if ((obs_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
        errors++;
        $display("FAIL tx_fill[%0d]: got %h expected %h", i, obs_vec & exp_mask(), exp_vec() & exp_mask());
      end
    end
    iowrite = 1'b0;
    checks++;
    if (tx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL tx_overflow_set: got %b expected 1", tx_overflow);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== wr[i]) begin
        errors++;
        $display("FAIL tx_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, wr[i]);
      end
      step();
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tx_empty_after_drain: got %b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_int();
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    step();
    rx_valid = 1'b0;
    checks++;
    if (io_int !== 1'b1 || ioin !== 8'hA5) begin
      errors++;
      $display("FAIL rx_push_int: got int=%b ioin=%h expected int=1 ioin=a5", io_int, ioin);
    end
    ioread = 1'b1;
    step();
    ioread = 1'b0;
    checks++;
    if (io_int !== 1'b0 || ioin !== 8'h00 || rx_underflow !== 1'b0) begin
      errors++;
      $display("FAIL rx_pop_int: got int=%b ioin=%h unf=%b expected 0 00 0", io_int, ioin, rx_underflow);
    end
    ioread = 1'b1;
    step();
    ioread = 1'b0;
    checks++;
    if (rx_underflow !== 1'b1 || (obs_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
      errors++;
      $display("FAIL rx_underflow: got %h expected %h", obs_vec & exp_mask(), exp_vec() & exp_mask());
    end
  endtask

  task automatic test_rx_full();
    logic [7:0] rd [4];
    rd[0] = 8'h02; rd[1] = 8'h03; rd[2] = 8'h04; rd[3] = 8'hEE;
    for (int i = 1; i <= 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      step();
    end
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_full_ready: got %b expected 0", rx_ready);
    end
    rx_data = 8'hEE;
    step();
    checks++;
    if (rx_ready !== 1'b0 || ioin !== 8'h01) begin
      errors++;
      $display("FAIL rx_full_hold: got ready=%b ioin=%h expected 0 01", rx_ready, ioin);
    end
    ioread = 1'b1;
    step();
    ioread = 1'b0;
    checks++;
    if (rx_ready !== 1'b1 || (obs_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
      errors++;
      $display("FAIL rx_pop_frees: got %h expected %h", obs_vec & exp_mask(), exp_vec() & exp_mask());
    end
    step();
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ioin !== rd[i] || io_int !== 1'b1) begin
        errors++;
        $display("FAIL rx_read_order[%0d]: got ioin=%h int=%b expected %h 1", i, ioin, io_int, rd[i]);
      end
      ioread = 1'b1;
      step();
      ioread = 1'b0;
    end
    checks++;
    if (io_int !== 1'b0) begin
      errors++;
      $display("FAIL rx_drained_int: got %b expected 0", io_int);
    end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iowrite = 1'b1;
      ioout   = 8'($urandom);
      step();
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iowrite = 1'b1;
      ioout   = 8'($urandom);
      step();
      checks++;
      if ((obs_vec & exp_mask()) !== (exp_vec() & exp_mask()) || tx_q.size() != 2) begin
        errors++;
        $display("FAIL b2b_stream[%0d]: got %h expected %h", i, obs_vec & exp_mask(), exp_vec() & exp_mask());
      end
    end
    iowrite  = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    step();
    rx_valid = 1'b0;
    ioread   = 1'b1;
    iowrite  = 1'b1;
    ioout    = 8'h3C;
    tx_ready = 1'b0;
    step();
    ioread  = 1'b0;
    iowrite = 1'b0;
    checks++;
    if ((obs_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
      errors++;
      $display("FAIL rd_wr_same_cycle: got %h expected %h", obs_vec & exp_mask(), exp_vec() & exp_mask());
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tx_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      iowrite  = $urandom_range(0, 1) == 1;
      ioout    = 8'($urandom);
      ioread   = $urandom_range(0, 2) == 0;
      tx_ready = $urandom_range(0, 2) != 0;
      rx_valid = $urandom_range(0, 1) == 1;
      rx_data  = 8'($urandom);
      step();
      checks++;
      if ((obs_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs_vec & exp_mask(), exp_vec() & exp_mask());
      end
    end
    reset = 1'b0; iowrite = 1'b0; ioread = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iowrite  = 1'b1;
      ioout    = 8'($urandom);
      rx_valid = (i < 2);
      rx_data  = 8'($urandom);
      step();
    end
    iowrite  = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || io_int !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: got tx_valid=%b int=%b expected 1 1", tx_valid, io_int);
    end
    reset = 1'b1;
    step();
    reset    = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ((obs_vec & 21'h100FFF) !== 21'h000800) begin
        errors++;
        $display("FAIL mid_reset[%0d]: got %h expected %h", i, obs_vec & 21'h100FFF, 21'h000800);
      end
      step();
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_rx_int();
    test_rx_full();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_io_responder
